// File: rtl/instruction_fetch.sv
// Instruction fetch: issues one memory read per accepted PC and
// queues returned instructions with their addresses for decode.
module instruction_fetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_valid,
    output logic          pc_ready,
    input  logic          Flush,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] instr_out,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          inflight;
    logic [AW-1:0] pend_pc;

    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] pc_q   [DEPTH];

    logic [CW-1:0] reserved;
    logic          accept;
    logic          wr_en;
    logic          pop;

    // An outstanding read already owns a slot, so it counts as occupied.
    assign reserved = count + CW'(inflight);

    assign pc_ready = !Reset && !Flush && (reserved < CW'(DEPTH));
    assign accept   = pc_valid && pc_ready;

    assign mem_rd   = accept;
    assign mem_addr = pc_in;

    assign instr_valid = !Reset && (count != '0);
    assign instr_out   = data_q[rd_ptr];
    assign instr_pc    = pc_q[rd_ptr];

    assign wr_en = inflight && !Flush && !Reset;
    assign pop   = instr_valid && instr_ready && !Flush;

    // Pointer, occupancy and outstanding-read tracking.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else if (Flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

    // Remember the address of the read in flight to tag its return.
    always_ff @(posedge Clock) begin
        if (accept) begin
            pend_pc <= pc_in;
        end
    end

    // Buffer storage; contents are qualified by count and need no reset.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            data_q[wr_ptr] <= mem_data;
            pc_q[wr_ptr]   <= pend_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_instruction_fetch;

    localparam int DEPTH = 4;

    logic        Clock;
    logic        Reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        Flush;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    bit          pend;
    logic [31:0] pend_pc;

    instruction_fetch #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .pc_in(pc_in),
        .pc_valid(pc_valid),
        .pc_ready(pc_ready),
        .Flush(Flush),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .instr_out(instr_out),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory with one-cycle latency; garbage when no read was issued.
    always @(posedge Clock) begin
        if (mem_rd) mem_data <= mem_addr + 32'h100;
        else        mem_data <= $urandom;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t",
                      nm, act, exp, $time);
    endtask

    task automatic drive(input bit rst, input bit fl, input bit pv,
                         input logic [31:0] pc, input bit ir);
        Reset       = rst;
        Flush       = fl;
        pc_valid    = pv;
        pc_in       = pc;
        instr_ready = ir;
    endtask

    // One clock: compare DUT with the model, then advance the model.
    task automatic cycle();
        bit e_ready;
        bit e_valid;
        bit acc;
        #3;
        e_ready = !Reset && !Flush && ((q.size() + int'(pend)) < DEPTH);
        e_valid = !Reset && (q.size() != 0);
        acc     = pc_valid && e_ready;
        chk("pc_ready", 64'(pc_ready), 64'(e_ready));
        chk("mem_rd", 64'(mem_rd), 64'(acc));
        if (acc) chk("mem_addr", 64'(mem_addr), 64'(pc_in));
        chk("instr_valid", 64'(instr_valid), 64'(e_valid));
        if (e_valid) begin
            chk("instr_pc", 64'(instr_pc), 64'(q[0].pc));
            chk("instr_out", 64'(instr_out), 64'(q[0].data));
        end
        @(posedge Clock);
        if (Reset || Flush) begin
            q.delete();
            pend = 1'b0;
        end else begin
            if (e_valid && instr_ready) void'(q.pop_front());
            if (pend) q.push_back('{pend_pc, pend_pc + 32'h100});
            pend    = acc;
            pend_pc = pc_in;
        end
        if (q.size() > DEPTH) chk("model_overflow", 64'(q.size()), 64'(DEPTH));
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 1, 32'hDEAD, 1);
        #1;
        chk("rst_pc_ready", 64'(pc_ready), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        cycle();
        cycle();
    endtask

    initial begin
        mem_data = '0;
        pend     = 1'b0;
        pend_pc  = '0;
        drive(1, 0, 0, 0, 0);
        @(posedge Clock);
        #1;
        do_reset();

        // Streaming: data = addr+0x100, visible two cycles after accept.
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 1, 32'(c), 1);
            #1;
            if (c == 0) chk("post_rst_ready", 64'(pc_ready), 64'd1);
            if (c >= 2) begin
                chk("stream_valid", 64'(instr_valid), 64'd1);
                chk("stream_pc", 64'(instr_pc), 64'(c - 2));
                chk("stream_out", 64'(instr_out), 64'(c - 2 + 'h100));
            end
            cycle();
        end

        // Fill with decode stalled: exactly DEPTH accepts.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 1, 32'h20 + 32'(c), 0);
            #1;
            chk("fill_mem_rd", 64'(mem_rd), (c < DEPTH) ? 64'd1 : 64'd0);
            cycle();
        end
        drive(0, 0, 1, 32'h60, 1);
        #1;
        chk("full_pop_ready", 64'(pc_ready), 64'd0);
        chk("full_head_pc", 64'(instr_pc), 64'h20);
        cycle();
        drive(0, 0, 1, 32'h61, 0);
        #1;
        chk("freed_slot_rd", 64'(mem_rd), 64'd1);
        chk("freed_slot_pc", 64'(instr_pc), 64'h21);
        cycle();
        drive(0, 0, 1, 32'h62, 0);
        #1;
        chk("refull_ready", 64'(pc_ready), 64'd0);
        cycle();

        // Flush while a read is in flight.
        do_reset();
        drive(0, 0, 1, 32'h10, 1);
        cycle();
        drive(0, 1, 1, 32'h99, 1);
        #1;
        chk("flush_ready", 64'(pc_ready), 64'd0);
        chk("flush_mem_rd", 64'(mem_rd), 64'd0);
        cycle();
        drive(0, 0, 1, 32'h40, 1);
        #1;
        chk("after_flush_ready", 64'(pc_ready), 64'd1);
        chk("after_flush_valid", 64'(instr_valid), 64'd0);
        cycle();
        drive(0, 0, 0, 32'h0, 1);
        #1;
        chk("flushed_not_shown", 64'(instr_valid), 64'd0);
        cycle();
        #1;
        chk("redirect_valid", 64'(instr_valid), 64'd1);
        chk("redirect_pc", 64'(instr_pc), 64'h40);
        cycle();

        // Reset with count=3 and one read outstanding.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 1, 32'h80 + 32'(c), 0);
            cycle();
        end
        drive(1, 0, 1, 32'h90, 0);
        cycle();
        drive(1, 0, 1, 32'h91, 0);
        #1;
        chk("mid_rst_valid", 64'(instr_valid), 64'd0);
        chk("mid_rst_ready", 64'(pc_ready), 64'd0);
        cycle();
        drive(0, 0, 1, 32'h77, 1);
        cycle();
        drive(0, 0, 0, 32'h0, 1);
        cycle();
        #1;
        chk("post_rst_first_pc", 64'(instr_pc), 64'h77);
        cycle();

        // Push/pop at DEPTH-1 across several pointer wraps.
        do_reset();
        for (int c = 0; c < 3 * DEPTH + 4; c++) begin
            drive(0, 0, 1, 32'h200 + 32'(c), (c >= DEPTH));
            cycle();
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom,
                  ($urandom_range(0, 2) != 0));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
